// File: rtl/writeback_unit_if.sv
// writeback_unit_if
//   Groups every data/handshake signal of the write-back stage so the unit
//   and its environment connect through one bundle.
//   slave  : view used by writeback_unit (consumes results, drives the
//            register-file write port, the readies and the retire counter).
//   master : view used by the environment that supplies results.
//   Ports carried:
//     alu_valid_i / alu_rd_i / alu_data_i                ALU result (never stalls)
//     lsu_valid_i / lsu_ready_o / lsu_rd_i / lsu_funct3_i /
//     lsu_offset_i / lsu_rdata_i                         load result + handshake
//     mdu_valid_i / mdu_ready_o / mdu_rd_i / mdu_data_i  MDU result + handshake
//     reg_write_wb_o / reg_rd_wb_o / reg_data_rd_wb_o    register-file write port
//     retired_count_o                                    writes issued since reset
interface writeback_unit_if;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;

  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [2:0]  lsu_funct3_i;
  logic [1:0]  lsu_offset_i;
  logic [31:0] lsu_rdata_i;

  logic        mdu_valid_i;
  logic        mdu_ready_o;
  logic [4:0]  mdu_rd_i;
  logic [31:0] mdu_data_i;

  logic        reg_write_wb_o;
  logic [4:0]  reg_rd_wb_o;
  logic [31:0] reg_data_rd_wb_o;
  logic [31:0] retired_count_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_funct3_i, lsu_offset_i, lsu_rdata_i,
    output lsu_ready_o,
    input  mdu_valid_i, mdu_rd_i, mdu_data_i,
    output mdu_ready_o,
    output reg_write_wb_o, reg_rd_wb_o, reg_data_rd_wb_o, retired_count_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_funct3_i, lsu_offset_i, lsu_rdata_i,
    input  lsu_ready_o,
    output mdu_valid_i, mdu_rd_i, mdu_data_i,
    input  mdu_ready_o,
    input  reg_write_wb_o, reg_rd_wb_o, reg_data_rd_wb_o, retired_count_o
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit
//   Write-back stage: merges ALU, LSU and MDU results into a single
//   register-file write per cycle. Load data is extended on entry into the
//   LSU holding buffer. ALU results have absolute priority; LSU and MDU
//   buffers share the remaining slots round-robin. Writes to x0 are still
//   issued (so the register file's pending counts stay balanced) with the
//   data forced to zero.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_i  : synchronous active-low reset
//     bus    : writeback_unit_if.slave, all result inputs, the two ready
//              outputs, the register-file write port and the retire counter
module writeback_unit (
  input  logic             clk_i,
  input  logic             rst_i,
  writeback_unit_if.slave  bus
);

  // Which buffer gets the slot when both are full.
  typedef enum logic {
    PTR_LSU = 1'b0,
    PTR_MDU = 1'b1
  } rr_ptr_t;

  rr_ptr_t     rr_ptr;

  logic        lsu_full;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        mdu_full;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;

  logic        lsu_ready;
  logic        mdu_ready;
  logic        lsu_take;
  logic        mdu_take;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  logic        grant_lsu;
  logic        grant_mdu;
  logic        wr_valid;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;

  logic        reg_write_q;
  logic [4:0]  reg_rd_q;
  logic [31:0] reg_data_q;
  logic [31:0] retired_q;

  // Ready is held low during reset so nothing is accepted while upstream
  // units are being reset alongside us.
  assign lsu_ready = !lsu_full && rst_i;
  assign mdu_ready = !mdu_full && rst_i;
  assign lsu_take  = bus.lsu_valid_i && lsu_ready;
  assign mdu_take  = bus.mdu_valid_i && mdu_ready;

  assign bus.lsu_ready_o      = lsu_ready;
  assign bus.mdu_ready_o      = mdu_ready;
  assign bus.reg_write_wb_o   = reg_write_q;
  assign bus.reg_rd_wb_o      = reg_rd_q;
  assign bus.reg_data_rd_wb_o = reg_data_q;
  assign bus.retired_count_o  = retired_q;

  // Load extension. Halfwords only look at offset[1]; word loads and the
  // undefined funct3 codes pass the raw word through untouched.
  always_comb begin
    case (bus.lsu_offset_i)
      2'd0:    ld_byte = bus.lsu_rdata_i[7:0];
      2'd1:    ld_byte = bus.lsu_rdata_i[15:8];
      2'd2:    ld_byte = bus.lsu_rdata_i[23:16];
      default: ld_byte = bus.lsu_rdata_i[31:24];
    endcase
    ld_half = bus.lsu_offset_i[1] ? bus.lsu_rdata_i[31:16] : bus.lsu_rdata_i[15:0];
    case (bus.lsu_funct3_i)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'h0, ld_byte};
      3'b101:  load_ext = {16'h0, ld_half};
      default: load_ext = bus.lsu_rdata_i;
    endcase
  end

  // Arbitration: ALU first, then whichever buffer is full; if both are full
  // the round-robin pointer decides.
  always_comb begin
    grant_lsu = 1'b0;
    grant_mdu = 1'b0;
    wr_valid  = 1'b0;
    wr_rd     = bus.alu_rd_i;
    wr_data   = bus.alu_data_i;
    if (bus.alu_valid_i) begin
      wr_valid = 1'b1;
    end else if (lsu_full && (!mdu_full || rr_ptr == PTR_LSU)) begin
      grant_lsu = 1'b1;
      wr_valid  = 1'b1;
      wr_rd     = lsu_rd;
      wr_data   = lsu_data;
    end else if (mdu_full) begin
      grant_mdu = 1'b1;
      wr_valid  = 1'b1;
      wr_rd     = mdu_rd;
      wr_data   = mdu_data;
    end
  end

  // Buffers, pointer and the registered write port. A buffer can only be
  // granted while full and only accepts while empty, so grant and capture
  // never collide on the same buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lsu_full    <= 1'b0;
      lsu_rd      <= 5'd0;
      lsu_data    <= 32'h0;
      mdu_full    <= 1'b0;
      mdu_rd      <= 5'd0;
      mdu_data    <= 32'h0;
      rr_ptr      <= PTR_LSU;
      reg_write_q <= 1'b0;
      reg_rd_q    <= 5'd0;
      reg_data_q  <= 32'h0;
      retired_q   <= 32'h0;
    end else begin
      if (grant_lsu) begin
        lsu_full <= 1'b0;
      end else if (lsu_take) begin
        lsu_full <= 1'b1;
        lsu_rd   <= bus.lsu_rd_i;
        lsu_data <= load_ext;
      end

      if (grant_mdu) begin
        mdu_full <= 1'b0;
      end else if (mdu_take) begin
        mdu_full <= 1'b1;
        mdu_rd   <= bus.mdu_rd_i;
        mdu_data <= bus.mdu_data_i;
      end

      if (grant_lsu) begin
        rr_ptr <= PTR_MDU;
      end else if (grant_mdu) begin
        rr_ptr <= PTR_LSU;
      end

      reg_write_q <= wr_valid;
      if (wr_valid) begin
        reg_rd_q   <= wr_rd;
        reg_data_q <= (wr_rd == 5'd0) ? 32'h0 : wr_data;
        retired_q  <= retired_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit
//   Self-checking bench for writeback_unit: directed sequences for reset,
//   ALU streaming, load extension (table of vectors), contention, x0 and
//   reset with full buffers, followed by randomized traffic compared
//   against a queue-based reference model.
module tb_writeback_unit;

  logic clk_i = 1'b0;
  logic rst_i;

  writeback_unit_if wb_if ();

  writeback_unit dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (wb_if)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_vecs [8];

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } pend_t;

  // Reference model state.
  pend_t       m_lsu_q [$];
  pend_t       m_mdu_q [$];
  bit          m_next_mdu;
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic [31:0] exp_count;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic alu_v, input logic [4:0] alu_rd, input logic [31:0] alu_d,
    input logic lsu_v, input logic [4:0] lsu_rd, input logic [2:0] f3,
    input logic [1:0] off, input logic [31:0] rdata,
    input logic mdu_v, input logic [4:0] mdu_rd, input logic [31:0] mdu_d);
    wb_if.alu_valid_i  = alu_v;
    wb_if.alu_rd_i     = alu_rd;
    wb_if.alu_data_i   = alu_d;
    wb_if.lsu_valid_i  = lsu_v;
    wb_if.lsu_rd_i     = lsu_rd;
    wb_if.lsu_funct3_i = f3;
    wb_if.lsu_offset_i = off;
    wb_if.lsu_rdata_i  = rdata;
    wb_if.mdu_valid_i  = mdu_v;
    wb_if.mdu_rd_i     = mdu_rd;
    wb_if.mdu_data_i   = mdu_d;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,
                  1'b0, 5'd0, 32'h0);
  endtask

  task automatic applyReset();
    rst_i = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic checkWrite(input string name, input logic we,
                            input logic [4:0] rd, input logic [31:0] data);
    checkOutput({name, "_we"},   32'(wb_if.reg_write_wb_o),   32'(we));
    checkOutput({name, "_rd"},   32'(wb_if.reg_rd_wb_o),      32'(rd));
    checkOutput({name, "_data"}, wb_if.reg_data_rd_wb_o,      data);
  endtask

  // Load extension from the load-type rules, using shifts and masks.
  function automatic logic [31:0] modelExtend(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * 32'(off))) & 32'hFF;
    h = (w >> (16 * (32'(off) / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic void modelReset();
    m_lsu_q.delete();
    m_mdu_q.delete();
    m_next_mdu = 1'b0;
    exp_we     = 1'b0;
    exp_rd     = 5'd0;
    exp_data   = 32'h0;
    exp_count  = 32'h0;
  endfunction

  initial begin
    // Directed load-extension vectors.
    ld_vecs[0] = '{3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
    ld_vecs[1] = '{3'b100, 2'd1, 32'h80FF7F01, 32'h0000007F};
    ld_vecs[2] = '{3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
    ld_vecs[3] = '{3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01};
    ld_vecs[4] = '{3'b010, 2'd1, 32'h80FF7F01, 32'h80FF7F01};
    ld_vecs[5] = '{3'b011, 2'd2, 32'h80FF7F01, 32'h80FF7F01};
    ld_vecs[6] = '{3'b001, 2'd3, 32'h80FF7F01, 32'hFFFF80FF};
    ld_vecs[7] = '{3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF};

    // Reset then idle.
    rst_i = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk_i);
    checkWrite("rst", 1'b0, 5'd0, 32'h0);
    checkOutput("rst_count", wb_if.retired_count_o, 32'h0);
    checkOutput("rst_lsu_ready", 32'(wb_if.lsu_ready_o), 32'h0);
    checkOutput("rst_mdu_ready", 32'(wb_if.mdu_ready_o), 32'h0);
    rst_i = 1'b1;
    #1;
    checkOutput("idle_lsu_ready", 32'(wb_if.lsu_ready_o), 32'h1);
    checkOutput("idle_mdu_ready", 32'(wb_if.mdu_ready_o), 32'h1);
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("idle_we", 32'(wb_if.reg_write_wb_o), 32'h0);
      checkOutput("idle_count", wb_if.retired_count_o, 32'h0);
    end

    // ALU stream.
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,
                  1'b0, 5'd0, 32'h0);
    @(negedge clk_i);
    checkWrite("alu0", 1'b1, 5'd5, 32'h1234);
    checkOutput("alu0_count", wb_if.retired_count_o, 32'd1);
    applyStimulus(1'b1, 5'd6, 32'hFFFF, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,
                  1'b0, 5'd0, 32'h0);
    @(negedge clk_i);
    checkWrite("alu1", 1'b1, 5'd6, 32'hFFFF);
    checkOutput("alu1_count", wb_if.retired_count_o, 32'd2);
    idleInputs();
    @(negedge clk_i);
    checkWrite("alu_hold", 1'b0, 5'd6, 32'hFFFF);
    checkOutput("alu_hold_count", wb_if.retired_count_o, 32'd2);

    // Load extension table.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(9 + i), ld_vecs[i].f3,
                    ld_vecs[i].off, ld_vecs[i].rdata, 1'b0, 5'd0, 32'h0);
      @(negedge clk_i);
      idleInputs();
      checkOutput("ld_busy_ready", 32'(wb_if.lsu_ready_o), 32'h0);
      checkOutput("ld_busy_we", 32'(wb_if.reg_write_wb_o), 32'h0);
      @(negedge clk_i);
      checkWrite("ld", 1'b1, 5'(9 + i), ld_vecs[i].exp);
      checkOutput("ld_ready_back", 32'(wb_if.lsu_ready_o), 32'h1);
    end
    checkOutput("ld_count", wb_if.retired_count_o, 32'd10);
    @(negedge clk_i);

    // x0 write from the MDU.
    applyReset();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0,
                  1'b1, 5'd0, 32'hDEAD);
    @(negedge clk_i);
    idleInputs();
    checkOutput("x0_mdu_ready", 32'(wb_if.mdu_ready_o), 32'h0);
    @(negedge clk_i);
    checkWrite("x0", 1'b1, 5'd0, 32'h0);
    checkOutput("x0_count", wb_if.retired_count_o, 32'd1);

    // Contention: three ALU writes, then LSU rd7, then MDU rd8.
    applyReset();
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 3'b010, 2'd0, 32'h77,
                  1'b1, 5'd8, 32'h88);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checkWrite("cont_alu", 1'b1, 5'(1 + k), 32'(32'h11 * (k + 1)));
      checkOutput("cont_lsu_ready", 32'(wb_if.lsu_ready_o), 32'h0);
      checkOutput("cont_mdu_ready", 32'(wb_if.mdu_ready_o), 32'h0);
      if (k < 2)
        applyStimulus(1'b1, 5'(2 + k), 32'(32'h11 * (k + 2)), 1'b0, 5'd0,
                      3'd0, 2'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      else
        idleInputs();
    end
    @(negedge clk_i);
    checkWrite("cont_lsu", 1'b1, 5'd7, 32'h77);
    checkOutput("cont_lsu_ready_back", 32'(wb_if.lsu_ready_o), 32'h1);
    checkOutput("cont_mdu_still_low", 32'(wb_if.mdu_ready_o), 32'h0);
    @(negedge clk_i);
    checkWrite("cont_mdu", 1'b1, 5'd8, 32'h88);
    checkOutput("cont_mdu_ready_back", 32'(wb_if.mdu_ready_o), 32'h1);
    @(negedge clk_i);
    checkOutput("cont_end_we", 32'(wb_if.reg_write_wb_o), 32'h0);
    checkOutput("cont_count", wb_if.retired_count_o, 32'd5);

    // Reset while both buffers hold results.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 3'b010, 2'd0, 32'h1111,
                  1'b1, 5'd11, 32'h2222);
    @(negedge clk_i);
    idleInputs();
    rst_i = 1'b0;
    #1;
    checkOutput("rfull_lsu_ready", 32'(wb_if.lsu_ready_o), 32'h0);
    checkOutput("rfull_mdu_ready", 32'(wb_if.mdu_ready_o), 32'h0);
    @(negedge clk_i);
    checkWrite("rfull", 1'b0, 5'd0, 32'h0);
    checkOutput("rfull_count", wb_if.retired_count_o, 32'h0);
    rst_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("rfull_after_we", 32'(wb_if.reg_write_wb_o), 32'h0);
      checkOutput("rfull_after_count", wb_if.retired_count_o, 32'h0);
    end

    // Randomized traffic against the reference model.
    applyReset();
    modelReset();
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst;
      logic        a_v, l_v, m_v;
      logic [4:0]  a_rd, l_rd, m_rd;
      logic [31:0] a_d, l_w, m_d;
      logic [2:0]  l_f3;
      logic [1:0]  l_off;
      bit          lsu_hs, mdu_hs, got;
      pend_t       win;

      checkWrite("rnd", exp_we, exp_rd, exp_data);
      checkOutput("rnd_count", wb_if.retired_count_o, exp_count);

      r_rst = ($urandom_range(0, 99) != 0);
      a_v   = ($urandom_range(0, 2) == 0);
      l_v   = ($urandom_range(0, 1) == 0);
      m_v   = ($urandom_range(0, 1) == 0);
      a_rd  = 5'($urandom_range(0, 31));
      l_rd  = 5'($urandom_range(0, 31));
      m_rd  = 5'($urandom_range(0, 31));
      a_d   = $urandom;
      l_w   = $urandom;
      m_d   = $urandom;
      l_f3  = 3'($urandom_range(0, 7));
      l_off = 2'($urandom_range(0, 3));
      applyStimulus(a_v, a_rd, a_d, l_v, l_rd, l_f3, l_off, l_w, m_v, m_rd, m_d);
      rst_i = r_rst;
      #1;
      checkOutput("rnd_lsu_ready", 32'(wb_if.lsu_ready_o),
                  32'(m_lsu_q.size() == 0 && r_rst));
      checkOutput("rnd_mdu_ready", 32'(wb_if.mdu_ready_o),
                  32'(m_mdu_q.size() == 0 && r_rst));

      if (!r_rst) begin
        modelReset();
      end else begin
        lsu_hs = l_v && (m_lsu_q.size() == 0);
        mdu_hs = m_v && (m_mdu_q.size() == 0);
        got    = 1'b0;
        win    = '{5'd0, 32'h0};
        if (a_v) begin
          got = 1'b1;
          win = '{a_rd, a_d};
        end else if (m_lsu_q.size() != 0 && (m_mdu_q.size() == 0 || !m_next_mdu)) begin
          got = 1'b1;
          win = m_lsu_q.pop_front();
          m_next_mdu = 1'b1;
        end else if (m_mdu_q.size() != 0) begin
          got = 1'b1;
          win = m_mdu_q.pop_front();
          m_next_mdu = 1'b0;
        end
        if (lsu_hs) m_lsu_q.push_back('{l_rd, modelExtend(l_f3, l_off, l_w)});
        if (mdu_hs) m_mdu_q.push_back('{m_rd, m_d});
        exp_we = got;
        if (got) begin
          exp_rd    = win.rd;
          exp_data  = (win.rd == 5'd0) ? 32'h0 : win.data;
          exp_count = exp_count + 32'd1;
        end
      end
      @(negedge clk_i);
    end
    checkWrite("rnd_final", exp_we, exp_rd, exp_data);
    checkOutput("rnd_final_count", wb_if.retired_count_o, exp_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage of the core: collects completed results from the ALU, the load/store unit (LSU) and the multiply/divide unit (MDU), extends load data, and issues at most one register-file write per cycle on the `reg_write_wb / reg_rd_wb / reg_data_rd_wb` port. The register file decrements its per-register pending count on every such write, so every accepted result produces exactly one write pulse, including results targeting x0.

## Interface
- No parameters.
- `clk_i` in 1: the single clock; all state updates on rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `alu_valid_i` in 1: ALU result valid this cycle; ALU cannot stall, so this is always accepted.
- `alu_rd_i` in 5: ALU destination register.
- `alu_data_i` in 32: ALU result.
- `lsu_valid_i` in 1: load result valid.
- `lsu_ready_o` out 1: load result accepted when valid and ready are both high.
- `lsu_rd_i` in 5: load destination.
- `lsu_funct3_i` in 3: load type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- `lsu_offset_i` in 2: byte address bits [1:0].
- `lsu_rdata_i` in 32: raw aligned memory word.
- `mdu_valid_i` in 1, `mdu_ready_o` out 1: MDU handshake, same rules as LSU.
- `mdu_rd_i` in 5, `mdu_data_i` in 32: MDU destination and result.
- `reg_write_wb_o` out 1: register-file write strobe, one cycle per result.
- `reg_rd_wb_o` out 5: write destination.
- `reg_data_rd_wb_o` out 32: write data.
- `retired_count_o` out 32: number of writes issued since reset.

## Operation
- LSU and MDU each have a 1-entry holding buffer (valid bit, rd, 32-bit data).
  - `lsu_ready_o` = LSU buffer empty and `rst_i` high; `mdu_ready_o` likewise.
  - On handshake, the result is captured into the buffer at that edge.
  - Ready deasserts the next cycle. A source can deliver at most one result every 2 cycles.
- Load extension is applied when data enters the buffer:
  - Byte: byte = rdata[8*offset +: 8]; lb sign-extends, lbu zero-extends.
  - Halfword: uses offset[1] only; half = rdata[16*offset[1] +: 16]; lh sign-extends, lhu zero-extends.
  - lw and the undefined codes 011/110/111 pass rdata unchanged, ignoring offset.
- Arbitration happens every cycle, and the winner is registered onto the outputs.
  - Priority 1: `alu_valid_i` (direct input, not buffered).
  - Priority 2: between full LSU/MDU buffers, a round-robin pointer selects.
    - The pointer resets to LSU.
    - After an LSU grant it points to MDU; after an MDU grant it points to LSU.
    - If only one buffer is full, that buffer wins and the pointer still updates.
  - A granted buffer is cleared at the same edge the output registers load.
- x0 rule: if the winner's rd is 0, the write is still issued with `reg_write_wb_o`=1 and rd=0, but the data is forced to 32'h0. This keeps register-file pending counts balanced and keeps x0 at zero.
- `retired_count_o` increments by 1 on every cycle in which `reg_write_wb_o` is driven high for the next cycle. It wraps from 32'hFFFFFFFF to 0.
- If no source is eligible, the next cycle has `reg_write_wb_o`=0. rd and data then hold their last values.

## Timing
- Reset (`rst_i` low at an edge):
  - Outputs: `reg_write_wb_o`=0, `reg_rd_wb_o`=0, `reg_data_rd_wb_o`=0, `retired_count_o`=0.
  - Internal state: both buffers empty, pointer = LSU.
  - `lsu_ready_o`/`mdu_ready_o` are 0 while `rst_i` is low.
- Reset mid-operation: buffered results are discarded without a write. The register file and upstream units are reset together.
- Latency:
  - ALU: valid at cycle N produces the write at cycle N+1.
  - LSU/MDU: handshake at N; the earliest write is at N+2.
- Starvation: back-to-back ALU results indefinitely delay buffered results. The buffers hold their contents and never drop them; their ready stays low.
- Handshake at N with the ALU idle and the other buffer empty: the write appears at N+2, and ready returns high at N+2.
- LSU and MDU handshakes in the same cycle: writes occur in consecutive cycles, in pointer order.
- The write strobe is exactly 1 cycle per result; there are no duplicate writes.

## Test plan
- Reset then idle:
  - All outputs 0; readies high from the first cycle after `rst_i` goes high; `retired_count_o` stays 0.
- ALU stream: alu rd=5 data=32'h1234 at N, rd=6 data=32'hFFFF at N+1.
  - Writes (5,32'h1234) at N+1 and (6,32'hFFFF) at N+2; count=2.
- Load extension, with rdata=32'h80FF7F01:
  - lb off 3 gives 32'hFFFFFF80.
  - lbu off 1 gives 32'h0000007F.
  - lh off 2 gives 32'hFFFF80FF.
  - lhu off 0 gives 32'h00007F01.
  - lw gives 32'h80FF7F01.
- Contention: ALU valid on 3 consecutive cycles while the LSU (rd=7) and MDU (rd=8) hand off at the first of them.
  - Three ALU writes come first, then rd=7, then rd=8.
  - Both readies stay low until their respective writes.
- x0: MDU rd=0 data=32'hDEAD.
  - `reg_write_wb_o`=1, rd=0, data=32'h0; count increments.
- Reset with both buffers full:
  - No writes after reset; readies low during reset; count=0.
